// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - nibble-bus instruction fetch sequencer with jump redirect and instruction buffer (FETCH_BUF2_EN selects two-entry buffer)
module fetch_sequencer (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [3:0]  data,
    output logic        sync,
    output logic [11:0] pc,
    input  logic        pc_load,
    input  logic [11:0] pc_target,
    output logic [7:0]  instr,
    output logic        instr_valid,
    input  logic        instr_ready
);

`ifdef FETCH_BUF2_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    logic [2:0]  sub;
    logic [3:0]  temp;
    logic        accepted;
    logic        pending;
    logic [11:0] target;
    logic [1:0]  count;
    logic [7:0]  entry0;
`ifdef FETCH_BUF2_EN
    logic [7:0]  entry1;
`endif
    logic        pop;
    logic        push;
    logic        space;
    logic [7:0]  fetched;
    logic [3:0]  drive_nib;
    logic        drive_en;

    assign instr_valid = (count != 2'd0);
    assign instr       = entry0;
    assign pop         = instr_valid && instr_ready;
    assign space       = (count < DEPTH);
    assign fetched     = {temp, data};
    // A byte is kept only when no redirect is pending or arriving on this edge.
    assign push        = (sub == 3'd4) && (space || pop) && !pending && !pc_load;

    // Address nibble for the current subcycle; bus released outside subcycles 0-2 and in reset.
    always_comb begin
        drive_nib = 4'h0;
        drive_en  = 1'b0;
        case (sub)
            3'd0: begin drive_nib = pc[3:0];   drive_en = !reset; end
            3'd1: begin drive_nib = pc[7:4];   drive_en = !reset; end
            3'd2: begin drive_nib = pc[11:8];  drive_en = !reset; end
            default: begin drive_nib = 4'h0;   drive_en = 1'b0;   end
        endcase
    end

    assign data = drive_en ? drive_nib : 4'bzzzz;

    // Frame sequencing: subcycle counter, nibble capture, pc advance and jump redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            sub      <= 3'd0;
            sync     <= 1'b0;
            pc       <= 12'h000;
            pending  <= 1'b0;
            target   <= 12'h000;
            temp     <= 4'h0;
            accepted <= 1'b0;
        end else begin
            sub  <= sub + 3'd1;
            sync <= (sub == 3'd6);
            if (sub == 3'd3) begin
                temp <= data;
            end
            if (sub == 3'd4) begin
                accepted <= push;
            end
            // pc only moves at the frame boundary so one frame never mixes two addresses.
            if (sub == 3'd7) begin
                if (pc_load) begin
                    pc <= pc_target;
                end else if (pending) begin
                    pc <= target;
                end else if (accepted) begin
                    pc <= pc + 12'd1;
                end
            end
            if (pc_load) begin
                target  <= pc_target;
                pending <= (sub != 3'd7);
            end else if (sub == 3'd7) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef FETCH_BUF2_EN
    // Two-entry FIFO, oldest byte in entry0; a jump flush overrides push and pop.
    always_ff @(posedge clock) begin
        if (reset || pc_load) begin
            count  <= 2'd0;
            entry0 <= 8'h00;
            entry1 <= 8'h00;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= fetched;
                    end else begin
                        entry1 <= fetched;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= fetched;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= fetched;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    // Single-entry holding register; a jump flush overrides push and pop.
    always_ff @(posedge clock) begin
        if (reset || pc_load) begin
            count  <= 2'd0;
            entry0 <= 8'h00;
        end else if (push) begin
            entry0 <= fetched;
            count  <= 2'd1;
        end else if (pop) begin
            count  <= 2'd0;
        end
    end
`endif

endmodule
